// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: default sizes, address-width helper and FSM state type.
// INST_LOADER_CHECKSUM_EN adds the CHECK and ERROR states.
package inst_loader_pkg;

    localparam int DEF_MEM_LEN   = 32;
    localparam int DEF_INST_SIZE = 32;

    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
`ifdef INST_LOADER_CHECKSUM_EN
        CHECK = 3'd2,
        ERROR = 3'd5,
`endif
        RUN   = 3'd3,
        HALT  = 3'd4
    } state_t;

endpackage

// File: rtl/inst_loader.sv
// Streams a program into instruction memory, then releases the processor and waits for its done flag.
// Define INST_LOADER_CHECKSUM_EN to require a trailing XOR checksum word before the processor is released.
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   LOAD  | accepting program words, one memory write per word
//   CHECK | accepting the checksum word (INST_LOADER_CHECKSUM_EN only)
//   RUN   | processor released, waiting for cpu_done
//   HALT  | processor finished, waiting for start
//   ERROR | checksum mismatch, processor held (INST_LOADER_CHECKSUM_EN only)
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int  MEM_LEN   = DEF_MEM_LEN,
    parameter int  INST_SIZE = DEF_INST_SIZE,
    localparam int ADDR_SIZE = addr_bits(MEM_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [INST_SIZE-1:0] in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 mem_write_enable,
    output logic [ADDR_SIZE-1:0] mem_write_addr,
    output logic [INST_SIZE-1:0] mem_write_data,
    output logic                 cpu_run,
    input  logic                 cpu_done,
    output logic [ADDR_SIZE:0]   load_count,
    output logic                 error
);

    localparam logic [ADDR_SIZE:0] LAST_IDX = (ADDR_SIZE+1)'(MEM_LEN - 1);
    localparam logic [ADDR_SIZE:0] CNT_ONE  = (ADDR_SIZE+1)'(1);

    state_t state;
    logic   start_ok;
    logic   load_accept;
    logic   last_word;

`ifdef INST_LOADER_CHECKSUM_EN
    logic                 err_q;
    logic [INST_SIZE-1:0] csum;
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        start_ok = 1'b0;
        case (state)
            IDLE, HALT: start_ok = start;
`ifdef INST_LOADER_CHECKSUM_EN
            ERROR:      start_ok = start;
`endif
            default:    start_ok = 1'b0;
        endcase
    end

    assign load_accept = (state == LOAD) && in_valid && in_ready;
    // The pointer equals load_count, so hitting MEM_LEN-1 means this is the last slot.
    assign last_word   = in_last || (load_count == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            cpu_run  <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
            err_q    <= 1'b0;
`endif
        end else begin
            cpu_run <= 1'b0;
            if (start_ok) begin
                state    <= LOAD;
                in_ready <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
                err_q    <= 1'b0;
`endif
            end else begin
                case (state)
                    LOAD: begin
                        if (load_accept && last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            state    <= CHECK;
`else
                            state    <= RUN;
                            in_ready <= 1'b0;
`endif
                        end
                    end
`ifdef INST_LOADER_CHECKSUM_EN
                    CHECK: begin
                        if (in_valid && in_ready) begin
                            in_ready <= 1'b0;
                            if (in_data == csum) begin
                                state <= RUN;
                            end else begin
                                state <= ERROR;
                                err_q <= 1'b1;
                            end
                        end
                    end
`endif
                    // First RUN cycle carries the final write pulse, so cpu_run rises one cycle later.
                    RUN: begin
                        cpu_run <= !cpu_done;
                        if (cpu_done) state <= HALT;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write_enable <= 1'b0;
            mem_write_addr   <= '0;
            mem_write_data   <= '0;
            load_count       <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum             <= '0;
`endif
        end else begin
            mem_write_enable <= 1'b0;
            if (start_ok) begin
                load_count <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end else if (load_accept) begin
                mem_write_enable <= 1'b1;
                mem_write_addr   <= load_count[ADDR_SIZE-1:0];
                mem_write_data   <= in_data;
                load_count       <= load_count + CNT_ONE;
`ifdef INST_LOADER_CHECKSUM_EN
                csum             <= csum ^ in_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: a transaction-level model checked every cycle plus literal spot checks.
`timescale 1ns/1ps
module tb_inst_loader;

    localparam int MEM_LEN   = 32;
    localparam int INST_SIZE = 32;
    localparam int ADDR_SIZE = 5;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 in_valid;
    logic [INST_SIZE-1:0] in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 mem_write_enable;
    logic [ADDR_SIZE-1:0] mem_write_addr;
    logic [INST_SIZE-1:0] mem_write_data;
    logic                 cpu_run;
    logic                 cpu_done;
    logic [ADDR_SIZE:0]   load_count;
    logic                 error;

    inst_loader #(.MEM_LEN(MEM_LEN), .INST_SIZE(INST_SIZE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_write_addr   (mem_write_addr),
        .mem_write_data   (mem_write_data),
        .cpu_run          (cpu_run),
        .cpu_done         (cpu_done),
        .load_count       (load_count),
        .error            (error)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: the loader is in one phase of a program's life; words fill memory in order.
    localparam int P_IDLE = 0, P_LOAD = 1, P_CHECK = 2, P_RUN = 3, P_HALT = 4, P_ERR = 5;
    int                   m_phase    = P_IDLE;
    int                   m_count    = 0;
    bit                   m_we       = 1'b0;
    logic [ADDR_SIZE-1:0] m_addr     = '0;
    logic [INST_SIZE-1:0] m_data     = '0;
    logic [INST_SIZE-1:0] m_csum     = '0;
    bit                   m_err      = 1'b0;
    bit                   m_released = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_count = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
            m_csum = '0; m_err = 1'b0; m_released = 1'b0;
        end else begin
            m_we = 1'b0;
            case (m_phase)
                P_IDLE, P_HALT, P_ERR: if (start) begin
                    m_phase = P_LOAD; m_count = 0; m_csum = '0; m_err = 1'b0;
                end
                P_LOAD: if (in_valid) begin
                    m_we = 1'b1; m_addr = ADDR_SIZE'(m_count); m_data = in_data;
                    m_csum = m_csum ^ in_data;
                    m_count++;
                    if (in_last || m_count == MEM_LEN) begin
                        m_phase = CSUM ? P_CHECK : P_RUN;
                        m_released = 1'b0;
                    end
                end
                P_CHECK: if (in_valid) begin
                    if (in_data == m_csum) begin
                        m_phase = P_RUN; m_released = 1'b0;
                    end else begin
                        m_phase = P_ERR; m_err = 1'b1;
                    end
                end
                P_RUN: if (cpu_done) begin
                    m_phase = P_HALT; m_released = 1'b0;
                end else begin
                    m_released = 1'b1;
                end
                default: ;
            endcase
        end
    end

    logic [ADDR_SIZE-1:0] wr_addr_q[$];
    logic [INST_SIZE-1:0] wr_data_q[$];

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready), 64'(m_phase == P_LOAD || m_phase == P_CHECK));
        chk("mem_write_enable", 64'(mem_write_enable), 64'(m_we));
        if (!rst_n || m_we) begin
            chk("mem_write_addr", 64'(mem_write_addr), 64'(m_addr));
            chk("mem_write_data", 64'(mem_write_data), 64'(m_data));
        end
        chk("load_count", 64'(load_count), 64'(m_count));
        chk("cpu_run", 64'(cpu_run), 64'(m_phase == P_RUN && m_released));
        chk("error", 64'(error), 64'(m_err));
        if (mem_write_enable) begin
            wr_addr_q.push_back(mem_write_addr);
            wr_data_q.push_back(mem_write_data);
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [INST_SIZE-1:0] w, input bit last, input int gap);
        int budget = 20;
        in_valid = 1'b1; in_data = w; in_last = last;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for word %0h", w);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic finish_run();
        cpu_done = 1'b1;
        @(negedge clk);
        cpu_done = 1'b0;
        chk("halt_cpu_run", 64'(cpu_run), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; cpu_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(mem_write_enable), 64'd0);
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_load_count", 64'(load_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-word program ending with in_last.
        clear_log();
        do_start();
        send(32'h0000_0013, 1'b0, 0);
        send(32'h0010_0093, 1'b0, 0);
        send(32'h0020_8133, 1'b1, 0);
        @(negedge clk);
        chk("a_writes", 64'(wr_addr_q.size()), 64'd3);
        if (wr_addr_q.size() == 3) begin
            chk("a_addr0", 64'(wr_addr_q[0]), 64'd0);
            chk("a_addr2", 64'(wr_addr_q[2]), 64'd2);
            chk("a_data1", 64'(wr_data_q[1]), 64'h0010_0093);
            chk("a_data2", 64'(wr_data_q[2]), 64'h0020_8133);
        end
        chk("a_load_count", 64'(load_count), 64'd3);
        chk("a_cpu_run", 64'(cpu_run), 64'd1);

        // Halt, then reload with in_valid toggling.
        finish_run();
        clear_log();
        do_start();
        send(32'hDEAD_BEEF, 1'b0, 1);
        send(32'h1234_5678, 1'b0, 1);
        send(32'h0000_0001, 1'b1, 1);
        chk("d_writes", 64'(wr_addr_q.size()), 64'd3);
        if (wr_addr_q.size() == 3) begin
            chk("d_addr0", 64'(wr_addr_q[0]), 64'd0);
            chk("d_addr1", 64'(wr_addr_q[1]), 64'd1);
            chk("d_addr2", 64'(wr_addr_q[2]), 64'd2);
        end
        chk("d_cpu_run", 64'(cpu_run), 64'd1);
        finish_run();

        // Overflow: 33 words offered, only 32 may land.
        clear_log();
        do_start();
        for (int i = 0; i < 32; i++) send(32'h1000 + 32'(i), 1'b0, 0);
        chk("b_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_data = 32'h0000_2020;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("b_writes", 64'(wr_addr_q.size()), 64'd32);
        if (wr_addr_q.size() == 32) begin
            chk("b_last_addr", 64'(wr_addr_q[31]), 64'd31);
            chk("b_last_data", 64'(wr_data_q[31]), 64'h101F);
        end
        chk("b_load_count", 64'(load_count), 64'd32);
        chk("b_cpu_run", 64'(cpu_run), 64'd1);
        finish_run();

        // Reset in the middle of a load.
        do_start();
        send(32'hAAAA_0001, 1'b0, 0);
        send(32'hAAAA_0002, 1'b0, 0);
        in_valid = 1'b1; in_data = 32'hAAAA_0003;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("e_in_ready", 64'(in_ready), 64'd0);
        chk("e_we", 64'(mem_write_enable), 64'd0);
        chk("e_addr", 64'(mem_write_addr), 64'd0);
        chk("e_data", 64'(mem_write_data), 64'd0);
        chk("e_load_count", 64'(load_count), 64'd0);
        chk("e_cpu_run", 64'(cpu_run), 64'd0);
        clear_log();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("e_no_write", 64'(wr_addr_q.size()), 64'd0);

`ifdef INST_LOADER_CHECKSUM_EN
        clear_log();
        do_start();
        send(32'hA5A5_A5A5, 1'b0, 0);
        send(32'h0F0F_0F0F, 1'b1, 0);
        send(32'hAAAA_AAAA, 1'b0, 0);
        @(negedge clk);
        chk("c_writes", 64'(wr_addr_q.size()), 64'd2);
        chk("c_cpu_run", 64'(cpu_run), 64'd1);
        chk("c_error", 64'(error), 64'd0);
        finish_run();
        do_start();
        send(32'hA5A5_A5A5, 1'b0, 0);
        send(32'h0F0F_0F0F, 1'b1, 0);
        send(32'h0000_0000, 1'b0, 0);
        @(negedge clk);
        chk("c_bad_error", 64'(error), 64'd1);
        chk("c_bad_cpu_run", 64'(cpu_run), 64'd0);
        do_start();
        chk("c_err_cleared", 64'(error), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter MEM_LEN, default 32, the instruction memory depth in words.
REQ-002 SHALL have parameter INST_SIZE, default 32, the instruction word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port: clk  input  1  rising-edge clock.
REQ-005 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: start  input  1  single-cycle pulse that begins a program load.
REQ-007 SHALL have port: in_valid  input  1  source presents a word.
REQ-008 SHALL have port: in_data  input  INST_SIZE  word from the source.
REQ-009 SHALL have port: in_last  input  1  marks the final program word.
REQ-010 SHALL have port: in_ready  output  1  loader accepts the word.
REQ-011 SHALL have port: mem_write_enable  output  1  instruction memory write strobe.
REQ-012 SHALL have port: mem_write_addr  output  ADDR_SIZE  instruction memory write address.
REQ-013 SHALL have port: mem_write_data  output  INST_SIZE  instruction memory write data.
REQ-014 SHALL have port: cpu_run  output  1  releases the processor; the processor is held while low.
REQ-015 SHALL have port: cpu_done  input  1  the processor's done flag.
REQ-016 SHALL have port: load_count  output  ADDR_SIZE+1  number of words written in the current load.
REQ-017 SHALL have port: error  output  1  checksum mismatch flag.

Function
REQ-018 SHALL implement the states IDLE, LOAD, CHECK, RUN, HALT and ERROR.
REQ-019 SHALL, in IDLE, HALT or ERROR, go to LOAD on start and clear load_count and the write pointer to 0; start SHALL be ignored in all other states.
REQ-020 SHALL drive in_ready high only in LOAD and CHECK.
REQ-021 SHALL treat a word as accepted only when in_valid and in_ready are both high at a rising edge.
REQ-022 SHALL, for each word accepted in LOAD, pulse mem_write_enable for exactly one cycle, starting the cycle after acceptance, with address = pointer and data = word.
REQ-023 SHALL increment the pointer and load_count by 1 for each accepted LOAD word.
REQ-024 SHALL leave LOAD after accepting a word with in_last high, or after accepting word MEM_LEN-1, whichever comes first.
REQ-025 SHALL deassert in_ready in the cycle after the MEM_LEN-th word is accepted, so no write ever goes past address MEM_LEN-1.
REQ-026 SHALL, when leaving LOAD, go to CHECK if INST_LOADER_CHECKSUM_EN is defined, else to RUN.
REQ-027 SHALL hold cpu_run high only in RUN, and assert it the cycle after the final mem_write_enable pulse.
REQ-028 SHALL go from RUN to HALT on the first cycle cpu_done is sampled high.
REQ-029 SHALL ignore cpu_done outside RUN.
REQ-030 SHALL ignore in_last in CHECK, since the checksum word is always a single word.
REQ-031 SHALL never write memory in IDLE, RUN, HALT or ERROR, whatever in_valid does.

Reset
REQ-032 SHALL, while rst_n is low, force the state to IDLE and drive in_ready, mem_write_enable, cpu_run and error to 0, and load_count, mem_write_addr and mem_write_data to 0.
REQ-033 SHALL treat reset during LOAD as aborting the load, with no further writes; the partial memory contents SHALL NOT be erased.

Configuration
REQ-034 SHALL, with INST_LOADER_CHECKSUM_EN defined, keep a running XOR of all accepted LOAD words, reset to 0 on start.
REQ-035 SHALL, with INST_LOADER_CHECKSUM_EN defined, accept one checksum word in CHECK without writing it to memory, then go to RUN on a match or to ERROR on a mismatch.
REQ-036 SHALL, in ERROR, hold error high and cpu_run low until reset or start; start SHALL clear error.
REQ-037 SHALL, without INST_LOADER_CHECKSUM_EN, omit the CHECK and ERROR states and the XOR register, and tie error to 0.

Structure
REQ-038 SHALL take MEM_LEN, ADDR_SIZE, INST_SIZE and the state enum typedef from the shared definitions package and header; the module SHALL NOT define them locally.
REQ-039 SHALL be a single module with no sub-modules; the state register and the datapath registers SHALL be in separate always blocks.

Verification
REQ-040 SHALL cover: start, then 3 words 0x00000013, 0x00100093, 0x00208133 with in_last on the third -> writes to addr 0, 1, 2, load_count = 3, cpu_run = 1 the next cycle.
REQ-041 SHALL cover: 33 words streamed with in_valid held high -> exactly 32 writes (addr 0..31), in_ready low after the 32nd word, word 33 never accepted.
REQ-042 SHALL cover: in_valid toggled 1/0/1 with ready high -> writes only on handshake cycles and the address never skips.
REQ-043 SHALL cover: in RUN, cpu_done = 1 -> HALT with cpu_run = 0; then start -> reload from addr 0.
REQ-044 SHALL cover: rst_n low after 2 of 5 words -> all outputs 0 and state IDLE; in_valid afterwards causes no write.
REQ-045 SHALL cover, with INST_LOADER_CHECKSUM_EN defined: words 0xA5A5A5A5 and 0x0F0F0F0F followed by checksum 0xAAAAAAAA -> RUN; checksum 0x00000000 -> error = 1 and cpu_run = 0.
